// File: rtl/axi_lite_dmem_slave.sv
// axi_lite_dmem_slave: AXI4-Lite slave fronting a byte-writable word memory.
// Independent write and read paths. Out-of-range accesses answer SLVERR.
module axi_lite_dmem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h20000000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] S_AWADDR,
    input  logic [2:0]  S_AWPROT,
    input  logic        S_AWVALID,
    output logic        S_AWREADY,
    input  logic [31:0] S_WDATA,
    input  logic [3:0]  S_WSTRB,
    input  logic        S_WVALID,
    output logic        S_WREADY,
    output logic [1:0]  S_BRESP,
    output logic        S_BVALID,
    input  logic        S_BREADY,
    input  logic [31:0] S_ARADDR,
    input  logic [2:0]  S_ARPROT,
    input  logic        S_ARVALID,
    output logic        S_ARREADY,
    output logic [31:0] S_RDATA,
    output logic [1:0]  S_RRESP,
    output logic        S_RVALID,
    input  logic        S_RREADY
);
    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic        r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [31:0] r_awaddr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp, r_rresp;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_win, w_rin;
    logic [31:0] w_waddr, w_wdata, w_woff, w_roff;
    logic [3:0]  w_wstrb;
    logic [IW-1:0] w_widx, w_ridx;
    logic        w_unused;

    assign S_AWREADY = !r_aw_held && !r_bvalid;
    assign S_WREADY  = !r_w_held && !r_bvalid;
    assign S_ARREADY = !r_rvalid;
    assign S_BVALID  = r_bvalid;
    assign S_BRESP   = r_bresp;
    assign S_RVALID  = r_rvalid;
    assign S_RDATA   = r_rdata;
    assign S_RRESP   = r_rresp;

    assign w_aw_hs  = S_AWVALID && S_AWREADY;
    assign w_w_hs   = S_WVALID && S_WREADY;
    assign w_ar_hs  = S_ARVALID && S_ARREADY;
    // A held beat takes precedence; otherwise the beat handshaking this cycle is used.
    assign w_waddr  = r_aw_held ? r_awaddr : S_AWADDR;
    assign w_wdata  = r_w_held ? r_wdata : S_WDATA;
    assign w_wstrb  = r_w_held ? r_wstrb : S_WSTRB;
    assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_woff = w_waddr - BASE_ADDR;
    assign w_roff = S_ARADDR - BASE_ADDR;
    assign w_win  = (w_waddr >= BASE_ADDR) && ({1'b0, w_woff} < SPAN);
    assign w_rin  = (S_ARADDR >= BASE_ADDR) && ({1'b0, w_roff} < SPAN);
    assign w_widx = w_woff[IW+1:2];
    assign w_ridx = w_roff[IW+1:2];
    assign w_unused = ^{S_AWPROT, S_ARPROT, w_woff[31:IW+2], w_woff[1:0], w_roff[31:IW+2], w_roff[1:0]};

    // Storage is never reset; a commit coinciding with reset is dropped.
    always_ff @(posedge ACLK) begin
        if (w_commit && w_win && !ARESET)
            for (int i = 0; i < 4; i++)
                if (w_wstrb[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_win ? 2'b00 : 2'b10;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= S_AWADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= S_WDATA;
                    r_wstrb  <= S_WSTRB;
                end
                if (r_bvalid && S_BREADY) r_bvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rin ? r_mem[w_ridx] : 32'h0;
                r_rresp  <= w_rin ? 2'b00 : 2'b10;
            end else if (r_rvalid && S_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_dmem_slave.sv
// tb_axi_lite_dmem_slave: directed and randomized checks of the AXI-Lite memory
// slave against an associative-array model of the addressed words.
module tb_axi_lite_dmem_slave;
    localparam logic [31:0] BASE  = 32'h20000000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_cmp = 0, n_err = 0;
    logic [31:0] mdl [int];
    int pool [16];

    axi_lite_dmem_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AWADDR(awaddr), .S_AWPROT(3'b000), .S_AWVALID(awvalid), .S_AWREADY(awready),
        .S_WDATA(wdata), .S_WSTRB(wstrb), .S_WVALID(wvalid), .S_WREADY(wready),
        .S_BRESP(bresp), .S_BVALID(bvalid), .S_BREADY(bready),
        .S_ARADDR(araddr), .S_ARPROT(3'b101), .S_ARVALID(arvalid), .S_ARREADY(arready),
        .S_RDATA(rdata), .S_RRESP(rresp), .S_RVALID(rvalid), .S_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint la = longint'(a);
        return la >= longint'(BASE) && la <= longint'(BASE) + 4 * DEPTH - 1;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) >> 2);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!in_rng(a)) return;
        w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[widx(a)] = w;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int c = 0;
        logic [1:0] eb = in_rng(a) ? 2'b00 : 2'b10;
        awaddr = a; wdata = d; wstrb = s; bready = 0;
        while (!(aw_done && w_done) && c < 50) begin
            awvalid = !aw_done && c >= aw_dly;
            wvalid  = !w_done && c >= w_dly;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick;
            aw_done |= aw_hs; w_done |= w_hs; c++;
            awvalid = 0; wvalid = 0;
            if (aw_done && !w_done) begin
                chk("awready_held", 32'(awready), 32'd0);
                chk("bvalid_half", 32'(bvalid), 32'd0);
            end
            if (w_done && !aw_done) begin
                chk("wready_held", 32'(wready), 32'd0);
                chk("bvalid_half", 32'(bvalid), 32'd0);
            end
        end
        chk("wr_accept", 32'(aw_done && w_done), 32'd1);
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'(eb));
        model_write(a, d, s);
        for (int k = 0; k < b_dly; k++) begin
            tick;
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("bresp_hold", 32'(bresp), 32'(eb));
            chk("awready_busy", 32'(awready), 32'd0);
            chk("wready_busy", 32'(wready), 32'd0);
        end
        bready = 1;
        tick;
        bready = 0;
        chk("bvalid_clr", 32'(bvalid), 32'd0);
        chk("awready_ret", 32'(awready), 32'd1);
        chk("wready_ret", 32'(wready), 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, input int r_dly);
        int c = 0;
        logic [31:0] ed = in_rng(a) ? mdl[widx(a)] : 32'h0;
        logic [1:0]  er = in_rng(a) ? 2'b00 : 2'b10;
        araddr = a; arvalid = 1; rready = 0;
        while (!arready && c < 50) begin tick; c++; end
        chk("arready", 32'(arready), 32'd1);
        tick;
        arvalid = 0;
        chk("rvalid", 32'(rvalid), 32'd1);
        chk("rdata", rdata, ed);
        chk("rresp", 32'(rresp), 32'(er));
        for (int k = 0; k < r_dly; k++) begin
            tick;
            chk("rvalid_hold", 32'(rvalid), 32'd1);
            chk("rdata_hold", rdata, ed);
            chk("arready_busy", 32'(arready), 32'd0);
        end
        rready = 1;
        tick;
        rready = 0;
        chk("rvalid_clr", 32'(rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        repeat (3) tick;
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 0;
        tick;
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd1);
        chk("rst_arready", 32'(arready), 32'd1);

        // Same-cycle AW/W, then readback
        wr(32'h20000004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd(32'h20000004, 0);
        // W three cycles ahead of AW, single byte lane
        wr(32'h20000004, 32'h000000AA, 4'b0001, 3, 0, 0);
        rd(32'h20000004, 1);
        // Out-of-range write and read
        wr(32'h10000000, 32'h12345678, 4'hF, 0, 1, 0);
        rd(32'h60000000, 0);
        rd(32'h20000004, 0);
        // Held response with BREADY low
        wr(32'h20000010, 32'hCAFEF00D, 4'hF, 1, 0, 5);
        wr(32'h20000010, 32'h99999999, 4'b0000, 0, 0, 0);
        rd(32'h20000010, 2);
        // Address boundaries
        wr(32'h20000FFF, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        rd(32'h20000FFC, 0);
        wr(32'h20001000, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
        rd(32'h20001000, 0);
        rd(32'h1FFFFFFC, 0);
        wr(32'h20000002, 32'h77665544, 4'b1010, 0, 2, 0);
        rd(32'h20000001, 0);

        // Same-edge write and read of one word: read sees the old value
        wr(32'h2000000C, 32'h22222222, 4'hF, 0, 0, 0);
        awaddr = 32'h2000000C; wdata = 32'h11111111; wstrb = 4'hF; araddr = 32'h2000000C;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick;
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("rw_rvalid", 32'(rvalid), 32'd1);
        chk("rw_rdata_old", rdata, 32'h22222222);
        chk("rw_bvalid", 32'(bvalid), 32'd1);
        chk("rw_bresp", 32'(bresp), 32'd0);
        bready = 1; rready = 1;
        tick;
        bready = 0; rready = 0;
        chk("rw_bvalid_clr", 32'(bvalid), 32'd0);
        chk("rw_rvalid_clr", 32'(rvalid), 32'd0);
        model_write(32'h2000000C, 32'h11111111, 4'hF);
        rd(32'h2000000C, 0);

        // Reset while AW is held drops it; a lone W afterwards never completes
        wr(32'h20000008, 32'h55AA55AA, 4'hF, 0, 0, 0);
        awaddr = 32'h20000008; awvalid = 1;
        tick;
        awvalid = 0;
        chk("aw_held_ready", 32'(awready), 32'd0);
        rst = 1;
        #1;
        chk("async_awready", 32'(awready), 32'd1);
        chk("async_bvalid", 32'(bvalid), 32'd0);
        tick;
        rst = 0;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
        tick;
        wvalid = 0;
        chk("lone_w_held", 32'(wready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("lone_w_nob", 32'(bvalid), 32'd0);
        end
        rd(32'h20000008, 0);
        rst = 1;
        tick;
        rst = 0;
        tick;

        // Randomized traffic over a pool of words
        for (int i = 0; i < 16; i++) begin
            pool[i] = int'($urandom_range(0, DEPTH - 1));
            wr(BASE + 32'(pool[i]) * 4, $urandom, 4'hF, 0, 0, 0);
        end
        for (int i = 0; i < 60; i++) begin
            a = BASE + 32'(pool[$urandom_range(0, 15)]) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom;
                if (in_rng(a)) a ^= 32'h80000000;
            end
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                wr(a, d, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
            else
                rd(a, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_dmem_slave.md
AXI_LITE_DMEM_SLAVE -- requirements
Module: axi_lite_dmem_slave

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h20000000, meaning the first byte address served.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored (power of two).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with these ports: ACLK input 1, the clock; ARESET input 1, the asynchronous active-high reset.
REQ-004 The block SHALL have these write-address ports: S_AWADDR input 32; S_AWPROT input 3 (ignored); S_AWVALID input 1; S_AWREADY output 1.
REQ-005 The block SHALL have these write-data ports: S_WDATA input 32; S_WSTRB input 4 (byte enables); S_WVALID input 1; S_WREADY output 1.
REQ-006 The block SHALL have these write-response ports: S_BRESP output 2; S_BVALID output 1; S_BREADY input 1.
REQ-007 The block SHALL have these read-address ports: S_ARADDR input 32; S_ARPROT input 3 (ignored); S_ARVALID input 1; S_ARREADY output 1.
REQ-008 The block SHALL have these read-data ports: S_RDATA output 32; S_RRESP output 2; S_RVALID output 1; S_RREADY input 1.

Function
REQ-009 An address SHALL be in range iff BASE_ADDR <= addr <= BASE_ADDR + 4*DEPTH_WORDS - 1; word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-010 The write and read paths SHALL be fully independent and SHALL operate concurrently.
REQ-011 The write path SHALL accept AW and W in any order or in the same cycle, capturing each into its own holding register with flag aw_held / w_held.
REQ-012 S_AWREADY SHALL = !aw_held && !S_BVALID; S_WREADY SHALL = !w_held && !S_BVALID; both are combinational from registered state only, with no dependence on VALID.
REQ-013 A write SHALL commit on the rising edge at which both address and data are available (held or handshaking that cycle); at that edge S_BVALID<=1 and both held flags clear, giving one-cycle latency from the completing handshake to BVALID.
REQ-014 For an in-range commit, byte lane i of the word SHALL be written iff S_WSTRB[i]=1; WSTRB=4'b0000 writes nothing and still responds OKAY.
REQ-015 S_BRESP SHALL be 2'b00 (OKAY) in range, and 2'b10 (SLVERR) out of range with memory unchanged.
REQ-016 S_BVALID/S_BRESP SHALL hold stable until S_BREADY=1; BVALID clears on that edge, and no new AW/W is accepted while BVALID=1.
REQ-017 S_ARREADY SHALL = !S_RVALID.
REQ-018 On an AR handshake at edge N, the word SHALL be read and S_RVALID=1 with S_RDATA/S_RRESP valid from edge N (one-cycle latency).
REQ-019 An out-of-range read SHALL return S_RDATA=32'h0 and S_RRESP=2'b10; in range SHALL return S_RRESP=2'b00.
REQ-020 S_RVALID/S_RDATA/S_RRESP SHALL hold stable until S_RREADY=1; RVALID clears on that edge, and back-to-back reads therefore sustain one read per two cycles.
REQ-021 A read and a write to the same word at the same edge SHALL return the old data (read-first).
REQ-022 Back-to-back writes: with BREADY held high, the next AW/W SHALL be accepted the cycle after BVALID clears (one write per two cycles).

Reset
REQ-023 While ARESET=1 (asynchronously): S_BVALID=0, S_RVALID=0, aw_held=0, w_held=0, S_BRESP=2'b00, S_RRESP=2'b00, S_RDATA=32'h0; hence S_AWREADY=S_WREADY=S_ARREADY=1 after release.
REQ-024 Memory contents SHALL NOT be reset; a reset mid-transaction SHALL drop any held AW/W and pending response without committing the write.

Verification
REQ-025 AW 0x20000004 and W 0xDEADBEEF/STRB 4'hF in the same cycle, then AR 0x20000004 -> BVALID next cycle, BRESP=00; RDATA=0xDEADBEEF, RRESP=00.
REQ-026 W (0x000000AA, STRB 4'b0001) three cycles before AW 0x20000004, over prior 0xDEADBEEF -> WREADY low after W is captured; BVALID one cycle after AW; readback 0xDEADBEAA.
REQ-027 AW 0x10000000 with W 0x12345678; AR 0x60000000 -> BRESP=10, memory unchanged; RDATA=0, RRESP=10.
REQ-028 BREADY=0 for 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY=WREADY=0; both return to 1 the cycle after BREADY handshake.
REQ-029 Same-edge write 0x11111111 and read of a word holding 0x22222222 -> RDATA=0x22222222; a later read returns 0x11111111.
REQ-030 Assert ARESET for one cycle after AW is held but before W arrives -> the held AW is dropped; a subsequent W alone produces no BVALID; the word is unchanged.
